// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader for one CLB tile: streams bitstream words LSB-first onto ccff_head
// with a gated shift enable. Define CCFF_TAIL_CHECK_EN to add the 8-bit tail-integrity marker check.
module ccff_chain_loader #(
  parameter int         CHAIN_LEN = 1024,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] MARKER    = 8'hA5
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 9);
  localparam int BIT_W = $clog2(WORD_W + 1);
`ifdef CCFF_TAIL_CHECK_EN
  localparam int MARK_LEN = 8;
`else
  localparam int MARK_LEN = 0;
`endif
  localparam int TOTAL = CHAIN_LEN + MARK_LEN;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] WORD_CNT = BIT_W'(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

`ifdef CCFF_TAIL_CHECK_EN
  localparam state_t FIRST_STATE = S_MARK;
`else
  localparam state_t FIRST_STATE = S_LOAD;
`endif

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  shift_cnt_reg, shift_cnt_next;
  logic [WORD_W-1:0] buf_reg, buf_next;
  logic [BIT_W-1:0]  buf_cnt_reg, buf_cnt_next;
  logic              head_reg, head_next;
  logic              en_reg, en_next;
  logic              done_reg, done_next;
  logic              last_shift;

`ifdef CCFF_TAIL_CHECK_EN
  localparam logic [CNT_W-1:0] MARK_LAST_C = CNT_W'(MARK_LEN - 1);
  localparam logic [CNT_W-1:0] WIN_LO_C    = CNT_W'(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] WIN_HI_C    = CNT_W'(TOTAL);

  logic       mism_reg, mism_next;
  logic       err_reg, err_next;
  logic       in_window;
  logic [2:0] chk_idx;

  // shift_cnt_reg already counts the shift the chain performs at this edge,
  // so the tail seen now is the bit that shift pushes out.
  assign in_window = en_reg && (shift_cnt_reg >= WIN_LO_C) && (shift_cnt_reg <= WIN_HI_C);
  assign chk_idx   = 3'(shift_cnt_reg - WIN_LO_C);
`endif

  assign last_shift = (shift_cnt_reg == LAST_C);

  always_comb begin
    state_next     = state_reg;
    shift_cnt_next = shift_cnt_reg;
    buf_next       = buf_reg;
    buf_cnt_next   = buf_cnt_reg;
    head_next      = head_reg;
    en_next        = 1'b0;
    done_next      = done_reg;
    cfg_ready      = 1'b0;
    busy           = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
    mism_next = mism_reg;
    err_next  = err_reg;
    if (in_window && (ccff_tail != MARKER[chk_idx])) begin
      mism_next = 1'b1;
    end
`endif

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (state_reg == S_DONE) begin
          done_next = 1'b1;
`ifdef CCFF_TAIL_CHECK_EN
          err_next = mism_reg;
`endif
        end
        if (start) begin
          state_next     = FIRST_STATE;
          shift_cnt_next = '0;
          buf_cnt_next   = '0;
          done_next      = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
          err_next  = 1'b0;
          mism_next = 1'b0;
`endif
        end
      end

`ifdef CCFF_TAIL_CHECK_EN
      S_MARK: begin
        busy           = 1'b1;
        en_next        = 1'b1;
        head_next      = MARKER[shift_cnt_reg[2:0]];
        shift_cnt_next = shift_cnt_reg + CNT_ONE;
        if (shift_cnt_reg == MARK_LAST_C) begin
          state_next = S_LOAD;
        end
      end
`endif

      S_LOAD: begin
        busy = 1'b1;
        // Request the next word while the final buffered bit leaves, unless that bit ends the payload.
        cfg_ready = (buf_cnt_reg == '0) || ((buf_cnt_reg == BIT_ONE) && !last_shift);
        if (buf_cnt_reg != '0) begin
          en_next        = 1'b1;
          head_next      = buf_reg[0];
          buf_next       = buf_reg >> 1;
          buf_cnt_next   = buf_cnt_reg - BIT_ONE;
          shift_cnt_next = shift_cnt_reg + CNT_ONE;
          if (last_shift) begin
            state_next   = S_DRAIN;
            buf_cnt_next = '0;
          end
        end
        if (cfg_valid && cfg_ready) begin
          buf_next     = cfg_data;
          buf_cnt_next = WORD_CNT;
        end
      end

      S_DRAIN: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_reg     <= S_IDLE;
      shift_cnt_reg <= '0;
      buf_reg       <= '0;
      buf_cnt_reg   <= '0;
      head_reg      <= 1'b0;
      en_reg        <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_cnt_reg <= shift_cnt_next;
      buf_reg       <= buf_next;
      buf_cnt_reg   <= buf_cnt_next;
      head_reg      <= head_next;
      en_reg        <= en_next;
      done_reg      <= done_next;
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      mism_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      mism_reg <= mism_next;
      err_reg  <= err_next;
    end
  end

  assign err = err_reg;
`else
  logic unused_tail_marker;
  assign unused_tail_marker = ccff_tail ^ (^MARKER);
  assign err = 1'b0;
`endif

  assign ccff_head    = head_reg;
  assign chain_clk_en = en_reg;
  assign done         = done_reg;

endmodule
